// File: rtl/jk_driver.sv
// rtl/jk_driver.sv - JK flop-bank driver: turns a target word into one cycle of J/K excitation.
// Optional readback checking (err/err_cnt) is built only with JK_DRIVER_CHECK_EN defined.
module jk_driver #(
   parameter int WIDTH       = 8,
   parameter int TOGGLE_PREF = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [WIDTH-1:0] req_target,
   output logic             req_ready,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] shadow_q,
   output logic             done,
   output logic             err,
   output logic [7:0]       err_cnt
);

   typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_tgt;
   logic [WIDTH-1:0] r_shadow;
   logic [WIDTH-1:0] r_j;
   logic [WIDTH-1:0] r_k;
   logic             r_done;
   logic [WIDTH-1:0] w_j_next;
   logic [WIDTH-1:0] w_k_next;

   // Don't-cares either stay at 0 or complete the toggle code, so a bit is toggled or held.
   always_comb begin
      w_j_next = req_target & ~r_shadow;
      w_k_next = r_shadow & ~req_target;
      if (TOGGLE_PREF != 0) begin
         w_j_next = r_shadow ^ req_target;
         w_k_next = r_shadow ^ req_target;
      end
   end

   // j/k are registered at acceptance so they are valid exactly during the DRIVE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_tgt    <= '0;
         r_shadow <= '0;
         r_j      <= '0;
         r_k      <= '0;
         r_done   <= 1'b0;
      end else begin
         r_j    <= '0;
         r_k    <= '0;
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_tgt   <= req_target;
                  r_j     <= w_j_next;
                  r_k     <= w_k_next;
                  r_state <= DRIVE;
               end
            end
            DRIVE: begin
               r_shadow <= r_tgt;
               r_state  <= SETTLE;
            end
            SETTLE: begin
               r_done  <= 1'b1;
               r_state <= CHECK;
            end
            CHECK: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = (r_state == IDLE);
   assign j         = r_j;
   assign k         = r_k;
   assign shadow_q  = r_shadow;
   assign done      = r_done;

`ifdef JK_DRIVER_CHECK_EN
   logic       r_err;
   logic [7:0] r_err_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err     <= 1'b0;
         r_err_cnt <= 8'd0;
      end else if (r_state == CHECK && q_fb != r_tgt) begin
         r_err <= 1'b1;
         if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign err     = r_err;
   assign err_cnt = r_err_cnt;
`else
   logic w_unused_q_fb;
   assign w_unused_q_fb = ^q_fb;
   assign err     = 1'b0;
   assign err_cnt = 8'd0;
`endif

endmodule
